// File: rtl/mux3_rr_arbiter_if.sv
// Handshake/payload bundle between three requesters, the arbiter and the
// downstream port.
//   req[2:0]      per-slot request (slot i has a beat on di)
//   d0, d1, d2    per-slot payloads
//   out_ready     downstream accepts a beat this cycle
//   gnt[2:0]      one-hot grant, 000 when nobody owns the port
//   sel[1:0]      mux3 select (00 = d0, 01 = d1, 10 = d2)
//   y             selected payload
//   out_valid     current owner presents a beat
// The arbiter connects through the slave modport. The requester/downstream
// side connects through the master modport.
interface mux3_rr_arbiter_if #(
  parameter int unsigned WIDTH = 32
);
  logic [2:0]       req;
  logic [WIDTH-1:0] d0;
  logic [WIDTH-1:0] d1;
  logic [WIDTH-1:0] d2;
  logic             out_ready;
  logic [2:0]       gnt;
  logic [1:0]       sel;
  logic [WIDTH-1:0] y;
  logic             out_valid;

  modport master (
    output req, d0, d1, d2, out_ready,
    input  gnt, sel, y, out_valid
  );

  modport slave (
    input  req, d0, d1, d2, out_ready,
    output gnt, sel, y, out_valid
  );
endinterface

// File: rtl/mux3_rr_arbiter.sv
// Round-robin arbiter and sequencer for a shared 3-input datapath mux.
// The arbiter grants one owner at a time and drives the mux3 select. It
// forwards the owner's payload with a valid/ready handshake. An owner gives
// up the port after MAX_HOLD accepted beats when another slot is waiting.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-high; clears all state immediately
//   bus    mux3_rr_arbiter_if.slave:
//          inputs  req, d0..d2, out_ready
//          outputs gnt (registered), sel (registered), y, out_valid
// y and out_valid are combinational. y follows sel. out_valid follows the
// owner's req.
module mux3_rr_arbiter #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  mux3_rr_arbiter_if.slave     bus
);

  localparam int unsigned BEAT_W = 8;
  localparam logic [BEAT_W-1:0] BEAT_MAX = '1;

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        owner_q, owner_d;
  logic [1:0]        last_q, last_d;
  logic [BEAT_W-1:0] beats_q, beats_d;
  logic [2:0]        gnt_q, gnt_d;
  logic [1:0]        sel_q, sel_d;

  logic             out_valid_c;
  logic [WIDTH-1:0] y_c;

  // Rotated-priority search starting after base. Returns {found, slot}.
  function automatic logic [2:0] rr_pick(input logic [2:0] mask,
                                         input logic [1:0] base);
    logic [2:0] res;
    logic [1:0] idx;
    res = '0;
    for (int k = 1; k <= 3; k++) begin
      idx = 2'((int'(base) + k) % 3);
      if (!res[2] && mask[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  function automatic logic [2:0] onehot(input logic [1:0] idx);
    return 3'b001 << idx;
  endfunction

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= 2'd0;
      last_q  <= 2'd2;
      beats_q <= '0;
      gnt_q   <= 3'b000;
      sel_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      beats_q <= beats_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
    end
  end

  // Next-state, arbitration and handshake
  always_comb begin
    logic [2:0] pick;
    logic [2:0] others;
    logic       owner_req;
    logic       beat;
    logic       hold_done;

    state_d     = state_q;
    owner_d     = owner_q;
    last_d      = last_q;
    beats_d     = beats_q;
    gnt_d       = gnt_q;
    sel_d       = sel_q;
    pick        = '0;
    others      = bus.req & ~onehot(owner_q);
    owner_req   = |(bus.req & onehot(owner_q));
    out_valid_c = 1'b0;
    beat        = 1'b0;
    hold_done   = 1'b0;

    case (state_q)
      IDLE: begin
        if (|bus.req) begin
          pick    = rr_pick(bus.req, last_q);
          state_d = GRANT;
          owner_d = pick[1:0];
          gnt_d   = onehot(pick[1:0]);
          sel_d   = pick[1:0];
          beats_d = '0;
        end
      end

      GRANT: begin
        out_valid_c = owner_req;
        beat        = owner_req && bus.out_ready;
        // Hold expiry only releases when someone else is actually waiting.
        hold_done   = beat && (|others) &&
                      ((9'(beats_q) + 9'd1) >= 9'(MAX_HOLD));
        if (beat && beats_q != BEAT_MAX) beats_d = beats_q + 8'd1;

        if (!owner_req || hold_done) begin
          // Old owner is masked out, so the handoff goes to the next waiter.
          last_d = owner_q;
          pick   = rr_pick(others, owner_q);
          if (pick[2]) begin
            owner_d = pick[1:0];
            gnt_d   = onehot(pick[1:0]);
            sel_d   = pick[1:0];
            beats_d = '0;
          end else begin
            state_d = IDLE;
            gnt_d   = 3'b000;
            beats_d = '0;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // Datapath mux driven by the registered select
  always_comb begin
    case (sel_q)
      2'b01:   y_c = bus.d1;
      2'b10:   y_c = bus.d2;
      default: y_c = bus.d0;
    endcase
  end

  assign bus.gnt       = gnt_q;
  assign bus.sel       = sel_q;
  assign bus.y         = y_c;
  assign bus.out_valid = out_valid_c;

endmodule

// File: tb/tb_mux3_rr_arbiter.sv
// Bench for mux3_rr_arbiter. A cycle-level behavioural model (integer owner,
// -1 = none) is compared with the DUT on every falling edge. Directed
// scenarios add hand-computed literal checks.
module tb_mux3_rr_arbiter;
  localparam int unsigned W  = 8;
  localparam int unsigned MH = 4;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  mux3_rr_arbiter_if #(.WIDTH(W)) bus();

  mux3_rr_arbiter #(.WIDTH(W), .MAX_HOLD(MH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  int m_owner, m_last, m_beats, m_sel;
  int dut_cnt[3];
  bit log_en = 1'b0;
  int sel_log[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic int rr_pick(input logic [2:0] r, input int base);
    for (int k = 1; k <= 3; k++) begin
      if (r[(base + k) % 3]) return (base + k) % 3;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_last  = 2;
    m_beats = 0;
    m_sel   = 0;
    dut_cnt = '{0, 0, 0};
  endtask

  // Advance the model across one rising edge, given this cycle's inputs
  task automatic model_advance(input logic [2:0] r, input logic rdy);
    int         w;
    bit         valid, beat, rival;
    logic [2:0] others;
    if (m_owner < 0) begin
      w = rr_pick(r, m_last);
      if (w >= 0) begin
        m_owner = w; m_sel = w; m_beats = 0;
      end
    end else begin
      valid  = r[m_owner];
      beat   = valid && rdy;
      if (beat && m_beats < 255) m_beats++;
      others = r;
      others[m_owner] = 1'b0;
      rival  = (others != 3'b000);
      if (!valid || (beat && m_beats >= int'(MH) && rival)) begin
        m_last = m_owner;
        w = rr_pick(others, m_owner);
        if (w >= 0) begin
          m_owner = w; m_sel = w; m_beats = 0;
        end else begin
          m_owner = -1;
        end
      end
    end
  endtask

  // Per-cycle compare against the model
  initial begin
    logic [2:0]   exp_gnt;
    logic [W-1:0] exp_y;
    logic         exp_valid;
    model_reset();
    forever begin
      @(negedge clk);
      if (reset) begin
        model_reset();
        chk("rst_gnt", 32'(bus.gnt), 32'd0);
        chk("rst_sel", 32'(bus.sel), 32'd0);
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_y", 32'(bus.y), 32'(bus.d0));
      end else begin
        exp_gnt   = 3'b000;
        exp_valid = 1'b0;
        if (m_owner >= 0) begin
          exp_gnt[m_owner] = 1'b1;
          exp_valid = bus.req[m_owner];
        end
        case (m_sel)
          0:       exp_y = bus.d0;
          1:       exp_y = bus.d1;
          default: exp_y = bus.d2;
        endcase
        chk("model_gnt", 32'(bus.gnt), 32'(exp_gnt));
        chk("model_sel", 32'(bus.sel), 32'(m_sel));
        chk("model_valid", 32'(bus.out_valid), 32'(exp_valid));
        chk("model_y", 32'(bus.y), 32'(exp_y));
        if (bus.out_valid && bus.out_ready && bus.sel != 2'b11) begin
          dut_cnt[bus.sel]++;
          if (log_en) sel_log.push_back(int'(bus.sel));
        end
        model_advance(bus.req, bus.out_ready);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    int cnt;
    bus.req = 3'b000; bus.d0 = 8'h0a; bus.d1 = 8'h00; bus.d2 = 8'h00;
    bus.out_ready = 1'b0;
    tick();
    tick();
    chk("init_gnt", 32'(bus.gnt), 32'd0);
    chk("init_sel", 32'(bus.sel), 32'd0);
    chk("init_valid", 32'(bus.out_valid), 32'd0);
    chk("init_y", 32'(bus.y), 32'h0a);

    // Single requester after reset
    reset = 1'b0;
    bus.req = 3'b010; bus.d1 = 8'h0c; bus.out_ready = 1'b1;
    tick();
    chk("single_gnt", 32'(bus.gnt), 32'b010);
    chk("single_sel", 32'(bus.sel), 32'b01);
    chk("single_y", 32'(bus.y), 32'h0c);
    chk("single_valid", 32'(bus.out_valid), 32'd1);
    bus.req = 3'b000;
    tick();
    tick();

    // All three requesting: 4 beats each in order 0, 1, 2, then 0 again
    do_reset();
    bus.req = 3'b111; bus.out_ready = 1'b1;
    bus.d0 = 8'h11; bus.d1 = 8'h22; bus.d2 = 8'h33;
    sel_log.delete();
    log_en = 1'b1;
    for (int i = 0; i < 13; i++) tick();
    log_en = 1'b0;
    chk("rr_len", 32'(sel_log.size()), 32'd12);
    for (int i = 0; i < 12; i++) begin
      if (i < sel_log.size()) chk("rr_sel", 32'(sel_log[i]), 32'(i / 4));
    end
    chk("rr_wrap_gnt", 32'(bus.gnt), 32'b001);

    // Back-pressure on slot 2 with slot 0 waiting
    do_reset();
    bus.d2 = 8'h30; bus.req = 3'b100; bus.out_ready = 1'b0;
    tick();
    bus.req = 3'b101;
    for (int i = 0; i < 5; i++) begin
      chk("bp_gnt", 32'(bus.gnt), 32'b100);
      chk("bp_sel", 32'(bus.sel), 32'b10);
      chk("bp_y", 32'(bus.y), 32'h30);
      tick();
    end
    bus.out_ready = 1'b1;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.gnt == 3'b001) break;
      tick();
      cnt++;
    end
    chk("bp_cycles_to_handoff", 32'(cnt), 32'd4);
    chk("bp_slot2_beats", 32'(dut_cnt[2]), 32'd4);
    chk("bp_handoff_sel", 32'(bus.sel), 32'b00);

    // Early drop by slot 0 after two beats
    do_reset();
    bus.req = 3'b011; bus.out_ready = 1'b1;
    tick();
    tick();
    tick();
    bus.req = 3'b010;
    #1;
    chk("drop_valid", 32'(bus.out_valid), 32'd0);
    chk("drop_slot0_beats", 32'(dut_cnt[0]), 32'd2);
    tick();
    chk("drop_gnt", 32'(bus.gnt), 32'b010);
    chk("drop_sel", 32'(bus.sel), 32'b01);

    // Sole requester keeps the grant past MAX_HOLD
    do_reset();
    bus.req = 3'b001; bus.out_ready = 1'b1;
    tick();
    for (int i = 0; i < 10; i++) begin
      chk("sole_gnt", 32'(bus.gnt), 32'b001);
      tick();
    end
    chk("sole_beats", 32'(dut_cnt[0]), 32'd10);

    // Reset mid-burst, then priority restarts from slot 0
    do_reset();
    bus.req = 3'b010; bus.out_ready = 1'b1;
    tick();
    tick();
    chk("mid_pre_gnt", 32'(bus.gnt), 32'b010);
    reset = 1'b1;
    #1;
    chk("mid_rst_gnt", 32'(bus.gnt), 32'd0);
    chk("mid_rst_sel", 32'(bus.sel), 32'd0);
    chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_y", 32'(bus.y), 32'(bus.d0));
    tick();
    reset = 1'b0;
    bus.req = 3'b110;
    tick();
    chk("mid_after_gnt", 32'(bus.gnt), 32'b010);
    chk("mid_after_sel", 32'(bus.sel), 32'b01);
    bus.req = 3'b000;
    tick();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
